// File: rtl/sync_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : sync_frame_controller
// Description : Sequencer for the OFDM receive synchronizer. Watches the
//               correlation-magnitude stream, holds the largest preamble
//               candidate for a programmable number of beats, then emits a
//               one-cycle max-sync strobe. Afterwards it counts synchronizer
//               output frames (tlast handshakes) to find end of packet, with
//               a stall timeout, and re-arms.
// Ports       :
//   axis_aclk / axis_aresetn      clock, asynchronous active-low reset
//   s_axis_metric_tdata/tvalid    correlation magnitude stream (no tready)
//   i_enable                      arm level
//   i_threshold, i_hold_len,
//   i_symbols, i_timeout          configuration, sampled only when arming
//   i_frm_tvalid/tready/tlast     monitored synchronizer output handshake
//   o_max_sync                    one-cycle strobe to synchronizer
//   o_busy, o_state               status (IDLE=0 SEARCH=1 TRIGGER=2 CAPTURE=3)
//   o_peak_value, o_peak_index    last triggered peak and its offset
//   o_frames_done                 completed packet count (wraps)
//   o_timeout_err                 one-cycle pulse on capture stall timeout
// Revision    : 1.0 - initial release
// ============================================================================
module sync_frame_controller #(
  parameter int g_METRIC_W  = 32,
  parameter int g_WIN_W     = 12,
  parameter int g_TIMEOUT_W = 24
) (
  input  logic                   axis_aclk,
  input  logic                   axis_aresetn,
  input  logic [g_METRIC_W-1:0]  s_axis_metric_tdata,
  input  logic                   s_axis_metric_tvalid,
  input  logic                   i_enable,
  input  logic [g_METRIC_W-1:0]  i_threshold,
  input  logic [g_WIN_W-1:0]     i_hold_len,
  input  logic [3:0]             i_symbols,
  input  logic [g_TIMEOUT_W-1:0] i_timeout,
  input  logic                   i_frm_tvalid,
  input  logic                   i_frm_tready,
  input  logic                   i_frm_tlast,
  output logic                   o_max_sync,
  output logic                   o_busy,
  output logic [1:0]             o_state,
  output logic [g_METRIC_W-1:0]  o_peak_value,
  output logic [g_WIN_W-1:0]     o_peak_index,
  output logic [15:0]            o_frames_done,
  output logic                   o_timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_TRIGGER = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  state_t                 state_q;

  // Configuration latched at arm time
  logic [g_METRIC_W-1:0]  thr_q;
  logic [g_WIN_W-1:0]     hold_len_q;
  logic [3:0]             symbols_q;
  logic [g_TIMEOUT_W-1:0] timeout_q;

  // Peak search
  logic                   have_cand_q;
  logic [g_METRIC_W-1:0]  cand_q;
  logic [g_WIN_W-1:0]     idx_q;
  logic [g_WIN_W-1:0]     peak_idx_q;
  logic [g_WIN_W-1:0]     hold_cnt_q;

  // Capture tracking
  logic [4:0]             frame_cnt_q;
  logic [g_TIMEOUT_W-1:0] stall_q;

  // Registered outputs
  logic                   max_sync_q;
  logic [g_METRIC_W-1:0]  peak_value_q;
  logic [g_WIN_W-1:0]     peak_index_q;
  logic [15:0]            frames_done_q;
  logic                   timeout_err_q;

  // Next-value helpers
  logic [g_WIN_W-1:0]     idx_d;
  logic [g_WIN_W-1:0]     hold_d;
  logic [4:0]             frame_cnt_d;
  logic [4:0]             frame_target;
  logic [g_TIMEOUT_W-1:0] stall_d;
  logic                   frm_hs;
  logic                   frm_beat;

  always_comb begin
    // Beat index saturates so a very long search never wraps back to zero
    idx_d        = (idx_q == '1) ? idx_q : idx_q + g_WIN_W'(1);
    hold_d       = hold_cnt_q + g_WIN_W'(1);
    frm_hs       = i_frm_tvalid & i_frm_tready;
    frm_beat     = frm_hs & i_frm_tlast;
    frame_cnt_d  = frame_cnt_q + 5'd1;
    // Preamble frame plus the data symbols
    frame_target = {1'b0, symbols_q} + 5'd1;
    stall_d      = frm_hs ? '0 : stall_q + g_TIMEOUT_W'(1);
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q       <= ST_IDLE;
      thr_q         <= '0;
      hold_len_q    <= '0;
      symbols_q     <= '0;
      timeout_q     <= '0;
      have_cand_q   <= 1'b0;
      cand_q        <= '0;
      idx_q         <= '0;
      peak_idx_q    <= '0;
      hold_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      stall_q       <= '0;
      max_sync_q    <= 1'b0;
      peak_value_q  <= '0;
      peak_index_q  <= '0;
      frames_done_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      max_sync_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_enable) begin
            thr_q       <= i_threshold;
            // A zero hold length behaves as one beat
            hold_len_q  <= (i_hold_len == '0) ? g_WIN_W'(1) : i_hold_len;
            symbols_q   <= i_symbols;
            timeout_q   <= i_timeout;
            have_cand_q <= 1'b0;
            state_q     <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (!i_enable) begin
            have_cand_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (s_axis_metric_tvalid) begin
            if (!have_cand_q) begin
              if (s_axis_metric_tdata > thr_q) begin
                have_cand_q <= 1'b1;
                cand_q      <= s_axis_metric_tdata;
                hold_cnt_q  <= '0;
                idx_q       <= '0;
                peak_idx_q  <= '0;
              end
            end else begin
              idx_q <= idx_d;
              // Strict compare: ties keep the earliest peak
              if (s_axis_metric_tdata > cand_q) begin
                cand_q     <= s_axis_metric_tdata;
                peak_idx_q <= idx_d;
                hold_cnt_q <= '0;
              end else begin
                hold_cnt_q <= hold_d;
                if (hold_d == hold_len_q) begin
                  // Strobe and peak report become visible during TRIGGER
                  max_sync_q   <= 1'b1;
                  peak_value_q <= cand_q;
                  peak_index_q <= peak_idx_q;
                  have_cand_q  <= 1'b0;
                  state_q      <= ST_TRIGGER;
                end
              end
            end
          end
        end
        ST_TRIGGER: begin
          frame_cnt_q <= '0;
          stall_q     <= '0;
          state_q     <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          stall_q <= stall_d;
          if (frm_beat) begin
            frame_cnt_q <= frame_cnt_d;
          end
          // Completion takes priority over timeout
          if (frm_beat && (frame_cnt_d == frame_target)) begin
            frames_done_q <= frames_done_q + 16'd1;
            state_q       <= ST_IDLE;
          end else if ((timeout_q != '0) && (stall_d == timeout_q)) begin
            timeout_err_q <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_max_sync    = max_sync_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_state       = state_q;
  assign o_peak_value  = peak_value_q;
  assign o_peak_index  = peak_index_q;
  assign o_frames_done = frames_done_q;
  assign o_timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_frame_controller
// Description : Directed self-checking bench for sync_frame_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_frame_controller;

  localparam int MW = 32;
  localparam int WW = 12;
  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [MW-1:0] metric;
  logic          mvalid;
  logic          enable;
  logic [MW-1:0] thr;
  logic [WW-1:0] hold_len;
  logic [3:0]    symbols;
  logic [TW-1:0] tmo;
  logic          f_valid;
  logic          f_ready;
  logic          f_last;
  logic          max_sync;
  logic          busy;
  logic [1:0]    state;
  logic [MW-1:0] peak_value;
  logic [WW-1:0] peak_index;
  logic [15:0]   frames_done;
  logic          timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_frame_controller #(
    .g_METRIC_W  (MW),
    .g_WIN_W     (WW),
    .g_TIMEOUT_W (TW)
  ) dut (
    .axis_aclk            (clk),
    .axis_aresetn         (rst_n),
    .s_axis_metric_tdata  (metric),
    .s_axis_metric_tvalid (mvalid),
    .i_enable             (enable),
    .i_threshold          (thr),
    .i_hold_len           (hold_len),
    .i_symbols            (symbols),
    .i_timeout            (tmo),
    .i_frm_tvalid         (f_valid),
    .i_frm_tready         (f_ready),
    .i_frm_tlast          (f_last),
    .o_max_sync           (max_sync),
    .o_busy               (busy),
    .o_state              (state),
    .o_peak_value         (peak_value),
    .o_peak_index         (peak_index),
    .o_frames_done        (frames_done),
    .o_timeout_err        (timeout_err)
  );

  // Advance one clock; inputs driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [MW-1:0] v);
    metric = v;
    mvalid = 1'b1;
    tick();
    mvalid = 1'b0;
  endtask

  task automatic apply_reset();
    enable  = 1'b0;
    metric  = '0;
    mvalid  = 1'b0;
    f_valid = 1'b0;
    f_ready = 1'b0;
    f_last  = 1'b0;
    rst_n   = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_cfg(input int t, input int h, input int s, input int to);
    thr      = MW'(t);
    hold_len = WW'(h);
    symbols  = 4'(s);
    tmo      = TW'(to);
  endtask

  // Arms with thr=4, hold=1 and walks through a 5,3 peak into CAPTURE
  task automatic arm_to_capture(input int s, input int to);
    set_cfg(4, 1, s, to);
    enable = 1'b1;
    tick();
    beat(5);
    beat(3);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0; metric = '0; mvalid = 1'b0;
    f_valid = 1'b0; f_ready = 1'b0; f_last = 1'b0;
    set_cfg(0, 0, 0, 0);
    #3;
    n_cmp++;
    if ({max_sync, busy, state, peak_value, peak_index, frames_done, timeout_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ms=%0b busy=%0b st=%0d pv=%0d pi=%0d fd=%0d te=%0b, want all 0",
               max_sync, busy, state, peak_value, peak_index, frames_done, timeout_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_peak();
    int seq [8] = '{0, 0, 5, 9, 7, 3, 2, 2};
    apply_reset();
    set_cfg(4, 3, 0, 0);
    enable = 1'b1;
    tick();
    n_cmp++;
    if (state !== 2'd1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL arm_search: got st=%0d busy=%0b, want st=1 busy=1", state, busy);
    end
    for (int i = 0; i < 8; i++) begin
      beat(MW'(seq[i]));
      n_cmp++;
      if (max_sync !== (i == 6)) begin
        n_err++;
        $display("FAIL basic_strobe[%0d]: got %0b want %0b", i, max_sync, (i == 6));
      end
      if (i == 6) begin
        n_cmp++;
        if (peak_value !== 32'd9 || peak_index !== 12'd1 || state !== 2'd2) begin
          n_err++;
          $display("FAIL basic_peak: got pv=%0d pi=%0d st=%0d, want pv=9 pi=1 st=2",
                   peak_value, peak_index, state);
        end
      end
    end
    n_cmp++;
    if (state !== 2'd3) begin
      n_err++;
      $display("FAIL basic_capture: got st=%0d want 3", state);
    end
  endtask

  task automatic test_larger_peak();
    apply_reset();
    set_cfg(4, 3, 0, 0);
    enable = 1'b1;
    tick();
    beat(5); beat(9); beat(7); beat(12);
    tick(); tick();              // idle cycles: hold must not advance
    beat(3); beat(2);
    n_cmp++;
    if (max_sync !== 1'b0 || state !== 2'd1) begin
      n_err++;
      $display("FAIL larger_hold: got ms=%0b st=%0d, want ms=0 st=1", max_sync, state);
    end
    beat(2);
    n_cmp++;
    if (max_sync !== 1'b1 || peak_value !== 32'd12 || peak_index !== 12'd3) begin
      n_err++;
      $display("FAIL larger_peak: got ms=%0b pv=%0d pi=%0d, want ms=1 pv=12 pi=3",
               max_sync, peak_value, peak_index);
    end
    tick();
    n_cmp++;
    if (max_sync !== 1'b0 || state !== 2'd3) begin
      n_err++;
      $display("FAIL larger_single: got ms=%0b st=%0d, want ms=0 st=3", max_sync, state);
    end
  endtask

  task automatic test_tie_and_hold_zero();
    apply_reset();
    set_cfg(4, 3, 0, 0);
    enable = 1'b1;
    tick();
    beat(6); beat(9); beat(9); beat(9); beat(9);
    n_cmp++;
    if (max_sync !== 1'b1 || peak_value !== 32'd9 || peak_index !== 12'd1) begin
      n_err++;
      $display("FAIL tie_earliest: got ms=%0b pv=%0d pi=%0d, want ms=1 pv=9 pi=1",
               max_sync, peak_value, peak_index);
    end
    apply_reset();
    set_cfg(4, 0, 0, 0);
    enable = 1'b1;
    tick();
    beat(5);
    n_cmp++;
    if (max_sync !== 1'b0) begin
      n_err++;
      $display("FAIL hold0_early: got ms=%0b want 0", max_sync);
    end
    beat(5);
    n_cmp++;
    if (max_sync !== 1'b1 || peak_index !== 12'd0 || peak_value !== 32'd5) begin
      n_err++;
      $display("FAIL hold0_trigger: got ms=%0b pi=%0d pv=%0d, want ms=1 pi=0 pv=5",
               max_sync, peak_index, peak_value);
    end
  endtask

  task automatic test_no_trigger();
    int strobes = 0;
    apply_reset();
    set_cfg(10, 3, 0, 0);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 1000; i++) begin
      beat(10);
      if (max_sync === 1'b1) strobes++;
    end
    n_cmp++;
    if (strobes !== 0 || state !== 2'd1) begin
      n_err++;
      $display("FAIL no_trigger: got strobes=%0d st=%0d, want strobes=0 st=1", strobes, state);
    end
  endtask

  task automatic test_completion();
    apply_reset();
    arm_to_capture(9, 0);
    n_cmp++;
    if (state !== 2'd3) begin
      n_err++;
      $display("FAIL cmp_enter: got st=%0d want 3", state);
    end
    symbols = 4'd0;              // ignored until next arm
    f_valid = 1'b1; f_ready = 1'b0; f_last = 1'b1;
    tick();                      // tlast without tready: no frame
    f_ready = 1'b1; f_last = 1'b0;
    tick();                      // handshake without tlast: no frame
    for (int k = 1; k <= 10; k++) begin
      f_valid = 1'b1; f_ready = 1'b1; f_last = 1'b1;
      tick();
      f_valid = 1'b0; f_ready = 1'b0; f_last = 1'b0;
      if (k == 9) begin
        n_cmp++;
        if (state !== 2'd3 || frames_done !== 16'd0) begin
          n_err++;
          $display("FAIL cmp_nine: got st=%0d fd=%0d, want st=3 fd=0", state, frames_done);
        end
      end
    end
    n_cmp++;
    if (state !== 2'd0 || frames_done !== 16'd1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL cmp_done: got st=%0d fd=%0d busy=%0b, want st=0 fd=1 busy=0",
               state, frames_done, busy);
    end
    tick();
    n_cmp++;
    if (state !== 2'd1) begin
      n_err++;
      $display("FAIL cmp_rearm: got st=%0d want 1", state);
    end
  endtask

  task automatic test_reset_mid_capture();
    // Continues from SEARCH with thr=4, hold=1 latched and frames_done=1
    beat(5);
    beat(3);
    tick();
    n_cmp++;
    if (state !== 2'd3 || frames_done !== 16'd1 || peak_value !== 32'd5) begin
      n_err++;
      $display("FAIL mid_setup: got st=%0d fd=%0d pv=%0d, want st=3 fd=1 pv=5",
               state, frames_done, peak_value);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({max_sync, busy, state, peak_value, peak_index, frames_done, timeout_err} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: got ms=%0b busy=%0b st=%0d pv=%0d fd=%0d te=%0b, want all 0",
               max_sync, busy, state, peak_value, frames_done, timeout_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    int pulses = 0;
    apply_reset();
    arm_to_capture(9, 50);
    f_valid = 1'b1; f_ready = 1'b0; f_last = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (timeout_err === 1'b1) pulses++;
      if (k == 49) begin
        n_cmp++;
        if (state !== 2'd3 || timeout_err !== 1'b0) begin
          n_err++;
          $display("FAIL tmo_early: got st=%0d te=%0b, want st=3 te=0", state, timeout_err);
        end
      end
    end
    n_cmp++;
    if (timeout_err !== 1'b1 || state !== 2'd0 || frames_done !== 16'd0) begin
      n_err++;
      $display("FAIL tmo_fire: got te=%0b st=%0d fd=%0d, want te=1 st=0 fd=0",
               timeout_err, state, frames_done);
    end
    f_valid = 1'b0; f_last = 1'b0;
    tick();
    n_cmp++;
    if (timeout_err !== 1'b0 || pulses !== 1 || state !== 2'd1) begin
      n_err++;
      $display("FAIL tmo_pulse: got te=%0b pulses=%0d st=%0d, want te=0 pulses=1 st=1",
               timeout_err, pulses, state);
    end
  endtask

  task automatic test_enable_drop();
    apply_reset();
    set_cfg(4, 1, 0, 0);
    enable = 1'b1;
    tick();
    beat(5);                     // candidate held
    enable = 1'b0;
    beat(3);                     // would trigger if still enabled
    n_cmp++;
    if (state !== 2'd0 || max_sync !== 1'b0) begin
      n_err++;
      $display("FAIL drop_idle: got st=%0d ms=%0b, want st=0 ms=0", state, max_sync);
    end
    enable = 1'b1;
    tick();
    beat(3);                     // below threshold; old candidate must be gone
    n_cmp++;
    if (state !== 2'd1 || max_sync !== 1'b0) begin
      n_err++;
      $display("FAIL drop_discard: got st=%0d ms=%0b, want st=1 ms=0", state, max_sync);
    end
  endtask

  initial begin
    test_reset();
    test_basic_peak();
    test_larger_peak();
    test_tie_and_hold_zero();
    test_no_trigger();
    test_completion();
    test_reset_mid_capture();
    test_timeout();
    test_enable_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
